// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared floor/state types and call-scan helpers for the lift controller
package lift_pkg;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR_BOTTOM = 2'd0;
    localparam floor_t FLOOR_MIDDLE = 2'd1;
    localparam floor_t FLOOR_TOP    = 2'd2;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DWELL,
        FAULT
    } state_t;

    // Any latched call strictly above floor f.
    function automatic logic calls_above(input logic [2:0] pend, input floor_t f);
        logic r;
        case (f)
            FLOOR_BOTTOM: r = pend[2] | pend[1];
            FLOOR_MIDDLE: r = pend[2];
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    // Any latched call strictly below floor f.
    function automatic logic calls_below(input logic [2:0] pend, input floor_t f);
        logic r;
        case (f)
            FLOOR_TOP:    r = pend[1] | pend[0];
            FLOOR_MIDDLE: r = pend[0];
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lift_sync.sv
// rtl/lift_sync.sv - multi-stage input synchroniser, resets to all-ones (inactive for active-low inputs)
//
// Ports:
//   clock  in        rising-edge clock
//   reset  in        synchronous, active-high; loads all stages with ones
//   d      in  W     asynchronous inputs
//   q      out W     inputs delayed by STAGES clocks
module lift_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) begin
                stage_q[i] <= '1;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/lift_controller.sv
// rtl/lift_controller.sv - three-floor lift controller: call latching, SCAN scheduling, motor and door timing
//
// Optional feature macro: LIFT_WATCHDOG_EN (movement watchdog and FAULT state)
//
// Ports:
//   clock         in       rising-edge clock
//   reset         in       synchronous, active-high
//   top           in       active-low, lift at floor 2
//   middle_plus   in       active-low upper middle sensor
//   middle_minus  in       active-low lower middle sensor
//   bottom        in       active-low, lift at floor 0
//   call0..call2  in       active-low call buttons (pulses allowed)
//   direction     out      1 = up, 0 = down
//   enable        out      active-low motor enable
//   floor         out [2]  last confirmed floor
//   pending       out [3]  latched calls, bit n = floor n
//   door_open     out      high during dwell
//   fault         out      watchdog fault
module lift_controller
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000,
    parameter int SYNC_STAGES  = 2,
    parameter int WDOG_CYCLES  = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       top,
    input  logic       middle_plus,
    input  logic       middle_minus,
    input  logic       bottom,
    input  logic       call0,
    input  logic       call1,
    input  logic       call2,
    output logic       direction,
    output logic       enable,
    output logic [1:0] floor,
    output logic [2:0] pending,
    output logic       door_open,
    output logic       fault
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int DW     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    // Input synchronisation and decode
    logic [6:0] raw_in;
    logic [6:0] sync_in;

    assign raw_in = {call2, call1, call0, bottom, middle_minus, middle_plus, top};

    lift_sync #(
        .WIDTH  (7),
        .STAGES (SYNC_N)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_in)
    );

    logic       at0;
    logic       at1;
    logic       at2;
    logic       at_any;
    floor_t     at_floor;
    logic [2:0] calls;

    assign at2      = ~sync_in[0];
    // One middle sensor on its own means the car is between floors.
    assign at1      = ~sync_in[1] & ~sync_in[2];
    assign at0      = ~sync_in[3];
    assign calls    = ~sync_in[6:4];
    assign at_any   = at0 | at1 | at2;
    assign at_floor = at0 ? FLOOR_BOTTOM : (at2 ? FLOOR_TOP : FLOOR_MIDDLE);

    // State
    state_t        state_q,     state_d;
    logic          enable_q,    enable_d;
    logic          direction_q, direction_d;
    floor_t        floor_q,     floor_d;
    logic [2:0]    pending_q,   pending_d;
    logic          door_open_q, door_open_d;
    logic          last_up_q,   last_up_d;
    logic [DW-1:0] dwell_q,     dwell_d;
    logic          run;
    logic          want_up;
    logic          arrived;

`ifdef LIFT_WATCHDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          fault_q, fault_d;
`endif

    assign arrived = at_any && (at_floor != floor_q);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        last_up_d = last_up_q;
        dwell_d   = dwell_q;
        run       = 1'b0;
        want_up   = direction_q;

        case (state_q)
            INIT: begin
                run     = 1'b1;
                want_up = 1'b0;
                if (at_any) begin
                    floor_d = at_floor;
                    state_d = IDLE;
                    run     = 1'b0;
                end
            end

            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d = DWELL;
                end else if (last_up_q && calls_above(pending_q, floor_q)) begin
                    state_d = MOVE_UP;
                end else if (calls_below(pending_q, floor_q)) begin
                    state_d = MOVE_DOWN;
                end else if (calls_above(pending_q, floor_q)) begin
                    state_d = MOVE_UP;
                end
            end

            MOVE_UP: begin
                run       = 1'b1;
                want_up   = 1'b1;
                last_up_d = 1'b1;
                if (arrived) begin
                    floor_d = at_floor;
                end
                if (at2 || (arrived && pending_q[at_floor])) begin
                    state_d = DWELL;
                    run     = 1'b0;
                end
            end

            MOVE_DOWN: begin
                run       = 1'b1;
                want_up   = 1'b0;
                last_up_d = 1'b0;
                if (arrived) begin
                    floor_d = at_floor;
                end
                if (at0 || (arrived && pending_q[at_floor])) begin
                    state_d = DWELL;
                    run     = 1'b0;
                end
            end

            DWELL: begin
                // A fresh press for this floor keeps the door open instead of queueing.
                if (calls[floor_q]) begin
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = INIT;
            end
        endcase

`ifdef LIFT_WATCHDOG_EN
        wdog_d = '0;
        if (state_q inside {INIT, MOVE_UP, MOVE_DOWN}) begin
            if ((floor_d != floor_q) || (state_d != state_q)) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_LAST) begin
                state_d = FAULT;
                run     = 1'b0;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
        fault_d = (state_d == FAULT);
`endif

        if ((state_d == DWELL) && (state_q != DWELL)) begin
            dwell_d = DWELL_LOAD;
        end

        // Calls for the floor being dwelt at are absorbed, including on the entry cycle.
        pending_d = pending_q | calls;
        if (state_d == DWELL) begin
            pending_d[floor_d] = 1'b0;
        end

        door_open_d = (state_d == DWELL);

        // Direction only moves while the motor is off; the motor starts one cycle
        // later once direction already matches the wanted sense.
        direction_d = enable_q ? want_up : direction_q;
        enable_d    = ~(run && (direction_q == want_up));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT;
            enable_q    <= 1'b1;
            direction_q <= 1'b0;
            floor_q     <= FLOOR_BOTTOM;
            pending_q   <= 3'b000;
            door_open_q <= 1'b0;
            last_up_q   <= 1'b1;
            dwell_q     <= '0;
`ifdef LIFT_WATCHDOG_EN
            wdog_q      <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            direction_q <= direction_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            door_open_q <= door_open_d;
            last_up_q   <= last_up_d;
            dwell_q     <= dwell_d;
`ifdef LIFT_WATCHDOG_EN
            wdog_q      <= wdog_d;
            fault_q     <= fault_d;
`endif
        end
    end

    assign direction = direction_q;
    assign enable    = enable_q;
    assign floor     = floor_q;
    assign pending   = pending_q;
    assign door_open = door_open_q;

`ifdef LIFT_WATCHDOG_EN
    assign fault = fault_q;
`else
    // No watchdog in this build: fault is constant low.
    assign fault = 1'b0 && (WDOG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_lift_controller.sv
// tb/tb_lift_controller.sv - self-checking bench for lift_controller with a behavioural lift shaft
module tb_lift_controller;

    localparam int DWELL = 20;
    localparam int WDOG  = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       call0 = 1'b1;
    logic       call1 = 1'b1;
    logic       call2 = 1'b1;
    logic       top, middle_plus, middle_minus, bottom;
    logic       direction, enable, door_open, fault;
    logic [1:0] floor;
    logic [2:0] pending;

    lift_controller #(
        .DWELL_CYCLES (DWELL),
        .SYNC_STAGES  (2),
        .WDOG_CYCLES  (WDOG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .top          (top),
        .middle_plus  (middle_plus),
        .middle_minus (middle_minus),
        .bottom       (bottom),
        .call0        (call0),
        .call1        (call1),
        .call2        (call2),
        .direction    (direction),
        .enable       (enable),
        .floor        (floor),
        .pending      (pending),
        .door_open    (door_open),
        .fault        (fault)
    );

    always #10 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Shaft model: floors at heights 0, 40, 80; car moves one unit every two cycles.
    int h         = 20;
    int step_div  = 0;
    bit sens_dead = 1'b0;

    assign bottom       = sens_dead || (h > 2);
    assign top          = sens_dead || (h < 78);
    assign middle_minus = sens_dead || (h < 36) || (h > 42);
    assign middle_plus  = sens_dead || (h < 38) || (h > 44);

    always @(negedge clock) begin
        if (enable == 1'b0) begin
            step_div = step_div + 1;
            if (step_div >= 2) begin
                step_div = 0;
                if (direction) h = (h < 80) ? h + 1 : 80;
                else           h = (h > 0)  ? h - 1 : 0;
            end
        end
    end

    // Door / direction monitor
    int   served[$];
    int   lens[$];
    int   door_len  = 0;
    int   seen_mask = 0;
    logic mon_door  = 1'b0;
    logic mon_dir   = 1'b0;
    logic mon_en    = 1'b1;
    logic rst_edge  = 1'b1;

    always @(posedge clock) rst_edge <= reset;

    always @(negedge clock) begin
        if (!rst_edge && (direction !== mon_dir)) begin
            vectors++;
            if (!(mon_en === 1'b1 && enable === 1'b1)) begin
                miscompares++;
                $display("FAIL dir_change_while_running: enable was %0b now %0b, required 1 and 1", mon_en, enable);
            end
        end
        mon_dir = direction;
        mon_en  = enable;
        seen_mask = seen_mask | (1 << int'(floor));
        if (door_open && !mon_door) begin
            served.push_back(int'(floor));
            door_len = 0;
        end
        if (door_open) door_len++;
        if (!door_open && mon_door) lens.push_back(door_len);
        mon_door = door_open;
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL global_timeout: got no finish, required finish before 90000 cycles");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: service order and resulting position from the SCAN rules.
    int m_floor   = 0;
    bit m_last_up = 1'b1;
    int mq[$];

    task automatic model_scan(input logic [2:0] m);
        int  pos;
        int  prev;
        bit  above;
        bit  below;
        bit  go_up;
        mq.delete();
        pos   = m_floor;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m[i] && i > pos) above = 1'b1;
            if (m[i] && i < pos) below = 1'b1;
        end
        if (m[pos]) mq.push_back(pos);
        go_up = (m_last_up && above) || !below;
        if (go_up) begin
            for (int i = pos + 1; i <= 2; i++) if (m[i]) mq.push_back(i);
            for (int i = pos - 1; i >= 0; i--) if (m[i]) mq.push_back(i);
        end else begin
            for (int i = pos - 1; i >= 0; i--) if (m[i]) mq.push_back(i);
            for (int i = pos + 1; i <= 2; i++) if (m[i]) mq.push_back(i);
        end
        prev = pos;
        foreach (mq[i]) begin
            if (mq[i] != prev) m_last_up = (mq[i] > prev);
            prev = mq[i];
        end
        m_floor = prev;
    endtask

    task automatic clear_mon();
        served.delete();
        lens.delete();
        seen_mask = 0;
    endtask

    task automatic pulse(input logic [2:0] m, input int w);
        @(negedge clock);
        call0 = ~m[0];
        call1 = ~m[1];
        call2 = ~m[2];
        repeat (w) @(negedge clock);
        call0 = 1'b1;
        call1 = 1'b1;
        call2 = 1'b1;
    endtask

    task automatic wait_quiet(output int guard);
        int quiet;
        quiet = 0;
        guard = 0;
        while (quiet < 8 && guard < 4000) begin
            @(negedge clock);
            guard++;
            if (pending == 3'b000 && !door_open && enable) quiet++;
            else quiet = 0;
        end
        chk("settle_timeout", int'(guard < 4000), 1);
    endtask

    task automatic settle(input int n, input int e0, input int e1, input int e2);
        int exp_f[3];
        int guard;
        exp_f[0] = e0;
        exp_f[1] = e1;
        exp_f[2] = e2;
        wait_quiet(guard);
        chk("served_count", served.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("served_floor[%0d]", i), (i < served.size()) ? served[i] : -1, exp_f[i]);
            chk($sformatf("dwell_len[%0d]", i), (i < lens.size()) ? lens[i] : -1, DWELL);
        end
        chk("final_floor", int'(floor), exp_f[n-1]);
        chk("final_pending", int'(pending), 0);
    endtask

    task automatic wait_home(input string name);
        int guard;
        guard = 0;
        while (enable !== 1'b1 && guard < 600) begin
            @(negedge clock);
            guard++;
        end
        chk({name, "_timeout"}, int'(guard < 600), 1);
    endtask

    typedef struct {
        logic [2:0] calls;
        int         width;
        int         n;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int guard;
        int cyc;
        logic [2:0] m;

        tbl[0] = '{3'b100, 50, 1, 2, 0, 0};
        tbl[1] = '{3'b001,  1, 1, 0, 0, 0};
        tbl[2] = '{3'b010,  1, 1, 1, 0, 0};
        tbl[3] = '{3'b101,  1, 2, 2, 0, 0};
        tbl[4] = '{3'b001,  1, 1, 0, 0, 0};
        tbl[5] = '{3'b110,  1, 2, 1, 2, 0};
        tbl[6] = '{3'b011,  1, 2, 1, 0, 0};
        tbl[7] = '{3'b111,  1, 3, 0, 1, 2};

        // Reset state, car parked between floors
        repeat (3) @(posedge clock);
        #1;
        chk("rst_enable",    int'(enable),    1);
        chk("rst_direction", int'(direction), 0);
        chk("rst_floor",     int'(floor),     0);
        chk("rst_pending",   int'(pending),   0);
        chk("rst_door",      int'(door_open), 0);
        chk("rst_fault",     int'(fault),     0);

        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("home_enable",    int'(enable),    0);
        chk("home_direction", int'(direction), 0);
        wait_home("home");
        chk("home_floor",   int'(floor),   0);
        chk("home_pending", int'(pending), 0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            pulse(tbl[i].calls, tbl[i].width);
            settle(tbl[i].n, tbl[i].e0, tbl[i].e1, tbl[i].e2);
            if (i == 0) chk("passed_floor1", (seen_mask >> 1) & 1, 1);
            model_scan(tbl[i].calls);
        end

        // From floor 2 heading for 0, call 1 while between 2 and 1
        clear_mon();
        pulse(3'b001, 1);
        guard = 0;
        while (h >= 60 && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        chk("between_wait", int'(guard < 400), 1);
        pulse(3'b010, 1);
        settle(2, 1, 0, 0);
        m_floor   = 0;
        m_last_up = 1'b0;

        // Re-press during dwell holds the door open and is not re-queued
        clear_mon();
        pulse(3'b001, 1);
        guard = 0;
        while (!door_open && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("reload_door_wait", int'(guard < 50), 1);
        repeat (8) @(negedge clock);
        pulse(3'b001, 1);
        wait_quiet(guard);
        chk("reload_served_count", served.size(), 1);
        chk("reload_extended", int'(lens.size() > 0 && lens[0] >= DWELL + 8), 1);

        // Randomised call sets against the SCAN model
        for (int r = 0; r < 10; r++) begin
            m = 3'($urandom_range(1, 7));
            model_scan(m);
            clear_mon();
            pulse(m, 1);
            settle(mq.size(), mq[0], (mq.size() > 1) ? mq[1] : 0, (mq.size() > 2) ? mq[2] : 0);
        end

        // Reset while moving up
        if (m_floor != 0) begin
            model_scan(3'b001);
            clear_mon();
            pulse(3'b001, 1);
            settle(mq.size(), mq[0], (mq.size() > 1) ? mq[1] : 0, 0);
        end
        pulse(3'b100, 1);
        guard = 0;
        while (h < 20 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        chk("midmove_wait", int'(guard < 300), 1);
        chk("midmove_running", int'(enable), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_enable",  int'(enable),    1);
        chk("midrst_pending", int'(pending),   0);
        chk("midrst_door",    int'(door_open), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rehome_enable",    int'(enable),    0);
        chk("rehome_direction", int'(direction), 0);
        wait_home("rehome");
        chk("rehome_floor", int'(floor), 0);
        m_floor   = 0;
        m_last_up = 1'b1;

`ifdef LIFT_WATCHDOG_EN
        // Dead sensors while moving
        sens_dead = 1'b1;
        pulse(3'b100, 1);
        cyc = 0;
        while (fault !== 1'b1 && cyc < 1300) begin
            @(negedge clock);
            cyc++;
        end
        chk("wdog_fault",      int'(fault),         1);
        chk("wdog_min_cycles", int'(cyc >= WDOG),   1);
        chk("wdog_enable",     int'(enable),        1);
        repeat (20) @(negedge clock);
        chk("wdog_fault_held",  int'(fault),  1);
        chk("wdog_enable_held", int'(enable), 1);
        sens_dead = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        wait_home("wdog_recover");
        chk("wdog_fault_cleared", int'(fault), 0);
`else
        cyc = 0;
        chk("no_wdog_fault", int'(fault) + cyc, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
